wb_bus_arbiter4: RTL and testbench
==================================

Name: wb_bus_arbiter4

Overview:
- Round-robin arbiter and sequencer for a 4-input, 32-bit select path onto one shared write-back/memory bus.
- Four requesters each present a data word and a request. The arbiter chooses one requester, drives the 2-bit select of the 4:1 data path and runs a valid/ready handshake with the target.
- Supports multi-beat bursts. No bubble cycle between consecutive grants.

Parameters:
- DW, 32, data width of each requester word and of the shared bus.
- TIMEOUT, 16, number of stalled BUSY cycles before a burst is aborted (used only with the optional feature; minimum 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  per-requester request/valid; held high while the requester has a beat pending.
- last  input  4  per-requester last-beat flag, qualified by req.
- data0  input  DW  requester 0 data.
- data1  input  DW  requester 1 data.
- data2  input  DW  requester 2 data.
- data3  input  DW  requester 3 data.
- out_ready  input  1  target accepts a beat this cycle.
- out_valid  output  1  shared bus carries a valid beat.
- out_data  output  DW  shared bus data.
- out_last  output  1  current beat is the last of its burst.
- sel  output  2  select code of the granted requester (00..11 = requester 0..3).
- grant  output  4  one-hot grant, registered.
- ack  output  4  one-hot beat-accepted strobe back to requesters.
- busy  output  1  arbiter in BUSY state.
- timeout_err  output  1  one-cycle abort pulse.

Behaviour:
- Reset: asynchronous, active-low (rst_n=0) clears all state regardless of clk. State=IDLE, grant=0000, sel=00, ptr=0, stall counter=0. Outputs out_valid, out_last, ack, busy, timeout_err and out_data are all 0.
- Reset mid-burst aborts the burst with no ack and no err.
- Two states, IDLE and BUSY.
- Arbitration is round-robin, scanning ptr, ptr+1, … ptr+3 (mod 4). The first requester with req=1 wins.
- On granting requester k: grant<=onehot(k), sel<=k, ptr<=(k+1) mod 4.
- IDLE: if any req=1, arbitrate and enter BUSY at the clock edge. Latency is 1 cycle: grant is visible in the cycle after req is first sampled. With no request, remain in IDLE.
- BUSY, combinational outputs:
  - out_valid = req[sel]
  - out_data = data[sel]
  - out_last = last[sel]
  - busy = 1
- A beat fires when out_valid && out_ready. Then ack[sel]=1 in that same cycle (combinational), all other ack bits 0.
- Beat with out_last=0: hold grant and sel; the burst is locked to that requester.
- Beat with out_last=1, other requesters pending: re-arbitrate in the same cycle, using the updated ptr. The new grant takes effect at the edge, so there is no bubble; state stays BUSY.
- Beat with out_last=1, no other request: go to IDLE. The finishing requester may immediately re-win only if it is the only requester with req=1.
- Granted requester drops req mid-burst: out_valid=0 and the grant is held. No re-arbitration happens until its last beat.
- out_ready=0: all outputs are held stable. Requesters must keep req, data and last stable until ack.
- IDLE outputs: out_data=0, out_valid=0, out_last=0, grant=0000. sel keeps its last value.
- ack is never asserted outside a firing beat.
- grant and sel change only at clock edges.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN
- Defined:
  - A stall counter increments each BUSY cycle with no fired beat and clears on every fired beat or on a new grant.
  - When the counter reaches TIMEOUT-1 and the current cycle still has no beat:
    - at the next edge the burst is aborted;
    - timeout_err pulses high for exactly 1 cycle;
    - the arbiter re-arbitrates as for a last beat, or goes to IDLE if no requests.
  - The aborted requester gets no ack.
- Undefined: no counter. The arbiter waits indefinitely and timeout_err is tied 0; the port stays present.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-burst -> grant=0000, sel=00, busy=0, out_valid=0 immediately, without a clock edge.
- Single beat: req=0001, last=0001, data0=32'hDEADBEEF, out_ready=1. Expect:
  - next cycle grant=0001, out_data=DEADBEEF, ack=0001;
  - following cycle IDLE.
- Fairness: req=1111 continuously, last=1111, out_ready=1 -> grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles, with no idle cycle.
- Burst lock: requester 1 sends a 3-beat burst (last on beat 3) while req2=1 throughout -> grant=0010 for 3 beats, then 0100 on the next cycle.
- Backpressure: out_ready=0 for 5 cycles during a grant -> grant, sel and out_data stable, ack=0000; the beat fires on the cycle out_ready returns to 1.
- Timeout (macro defined, TIMEOUT=16): out_ready=0 for 16 cycles with req=0011 and requester 0 granted -> timeout_err pulses once, no ack0, grant moves to 0010.

Source files
------------

// File: rtl/wb_bus_arbiter4.sv
// wb_bus_arbiter4: round-robin arbiter and sequencer that merges four requesters
// onto one shared write-back/memory bus through a 4:1 select path, with
// valid/ready handshaking and multi-beat burst locking.
//
// Optional feature macro: WB_ARB_TIMEOUT_EN
//   Defined   - a stall counter aborts a burst after TIMEOUT stalled BUSY cycles,
//               pulsing timeout_err for one cycle and re-arbitrating.
//   Undefined - no counter; the arbiter waits indefinitely, timeout_err is 0.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   req[3:0]     per-requester request/valid, held while a beat is pending
//   last[3:0]    per-requester last-beat flag, qualified by req
//   data0..3     requester data words
//   out_ready    target accepts a beat this cycle
//   out_valid    shared bus carries a valid beat
//   out_data     shared bus data (0 when idle)
//   out_last     current beat is the last of its burst
//   sel[1:0]     select code of the granted requester (held while idle)
//   grant[3:0]   registered one-hot grant (0 when idle)
//   ack[3:0]     one-hot beat-accepted strobe, only on a firing beat
//   busy         arbiter is in the BUSY state
//   timeout_err  one-cycle burst abort pulse
module wb_bus_arbiter4 #(
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    req,
    input  logic [3:0]    last,
    input  logic [DW-1:0] data0,
    input  logic [DW-1:0] data1,
    input  logic [DW-1:0] data2,
    input  logic [DW-1:0] data3,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic [1:0]    sel,
    output logic [3:0]    grant,
    output logic [3:0]    ack,
    output logic          busy,
    output logic          timeout_err
);

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("wb_bus_arbiter4: TIMEOUT must be at least 2");
    end

    typedef enum logic {StIdle, StBusy} state_e;

    state_e        state_q, state_d;
    logic [3:0]    grant_q, grant_d;
    logic [1:0]    sel_q, sel_d;
    logic [1:0]    ptr_q, ptr_d;

    logic          arb_found;
    logic [1:0]    arb_idx;
    logic [1:0]    cand;
    logic [DW-1:0] data_mux;
    logic          fire;
    logic          others;
    logic          take;
    logic          abort;

    // Round-robin pick: scan ptr, ptr+1, ptr+2, ptr+3. Iterating from the far end
    // lets the nearest requester overwrite the result last.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = ptr_q;
        cand      = '0;
        for (int i = 3; i >= 0; i--) begin
            cand = ptr_q + 2'(i);
            if (req[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    always_comb begin
        data_mux = data0;
        case (sel_q)
            2'd0:    data_mux = data0;
            2'd1:    data_mux = data1;
            2'd2:    data_mux = data2;
            default: data_mux = data3;
        endcase
    end

    assign busy      = (state_q == StBusy);
    assign out_valid = busy & req[sel_q];
    assign out_data  = busy ? data_mux : '0;
    assign out_last  = busy & last[sel_q];
    assign fire      = out_valid & out_ready;
    assign ack       = fire ? (4'b0001 << sel_q) : 4'b0000;
    // Only a competing requester justifies staying BUSY after a burst ends; the
    // finishing requester goes back through IDLE if it is alone.
    assign others    = |(req & ~grant_q);
    assign grant     = grant_q;
    assign sel       = sel_q;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] stall_q, stall_d;
    logic          terr_q;

    assign abort = busy & ~fire & (stall_q == CW'(TIMEOUT - 1));

    // Counts consecutive stalled BUSY cycles; any fired beat or new grant clears it.
    always_comb begin
        stall_d = '0;
        if (busy && !fire && !abort) begin
            stall_d = stall_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            terr_q  <= 1'b0;
        end else begin
            stall_q <= stall_d;
            terr_q  <= abort;
        end
    end

    assign timeout_err = terr_q;
`else
    assign abort       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        take    = 1'b0;
        case (state_q)
            StIdle: begin
                if (arb_found) begin
                    take = 1'b1;
                end
            end
            StBusy: begin
                // Burst ends on its last beat or on abort; re-arbitrate in the same
                // cycle so the next grant lands at the edge with no bubble.
                if ((fire && out_last) || abort) begin
                    if (others) begin
                        take = 1'b1;
                    end else begin
                        state_d = StIdle;
                        grant_d = 4'b0000;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = 4'b0000;
            end
        endcase
        if (take) begin
            state_d = StBusy;
            grant_d = 4'b0001 << arb_idx;
            sel_d   = arb_idx;
            ptr_d   = arb_idx + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            grant_q <= 4'b0000;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_wb_bus_arbiter4.sv
// Self-checking bench for wb_bus_arbiter4: directed steps from the test plan followed by
// randomized requester traffic, all compared against a transaction-level reference model.
module tb_wb_bus_arbiter4;

    localparam int unsigned DW      = 32;
    localparam int unsigned TIMEOUT = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    req;
    logic [3:0]    last;
    logic [DW-1:0] data0, data1, data2, data3;
    logic          out_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [1:0]    sel;
    logic [3:0]    grant;
    logic [3:0]    ack;
    logic          busy;
    logic          timeout_err;

    always #5 clk = ~clk;

    wb_bus_arbiter4 #(
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .last        (last),
        .data0       (data0),
        .data1       (data1),
        .data2       (data2),
        .data3       (data3),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_last    (out_last),
        .sel         (sel),
        .grant       (grant),
        .ack         (ack),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: who owns the bus (-1 = nobody), who won most recently, and
    // how long the current owner has gone without a beat.
    int   owner;
    int   last_winner;
    int   m_sel;
    int   stalls;
    logic m_terr;
    logic [3:0] m_ack;

    // Stimulus values applied at the start of each cycle.
    logic [3:0]    req_v, last_v;
    logic [DW-1:0] dv[4];
    logic          rdy_v;

    // DUT outputs captured in the most recent cycle.
    logic [3:0]    g_grant, g_ack;
    logic [DW-1:0] g_data;
    logic          g_busy, g_terr;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r);
        for (int off = 1; off <= 4; off++) begin
            int c;
            c = (last_winner + off) % 4;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        owner       = -1;
        last_winner = 3;
        m_sel       = 0;
        stalls      = 0;
        m_terr      = 1'b0;
        m_ack       = 4'b0000;
    endtask

    // Drive inputs (called just after a rising edge), check at the falling edge,
    // advance the model, and return 1 time unit after the next rising edge.
    task automatic cycle();
        logic [3:0]    grant_e;
        logic          valid_e, fire_e, last_e, abort;
        logic [DW-1:0] data_e;
        req       = req_v;
        last      = last_v;
        data0     = dv[0];
        data1     = dv[1];
        data2     = dv[2];
        data3     = dv[3];
        out_ready = rdy_v;
        #4;
        grant_e = (owner >= 0) ? 4'(1 << owner) : 4'b0000;
        valid_e = (owner >= 0) && req_v[owner];
        last_e  = (owner >= 0) && last_v[owner];
        data_e  = (owner >= 0) ? dv[owner] : '0;
        fire_e  = valid_e && rdy_v;
        m_ack   = fire_e ? grant_e : 4'b0000;

        g_grant = grant;
        g_ack   = ack;
        g_data  = out_data;
        g_busy  = busy;
        g_terr  = timeout_err;
        chk("grant", DW'(grant), DW'(grant_e));
        chk("sel", DW'(sel), DW'(m_sel));
        chk("busy", DW'(busy), DW'(owner >= 0));
        chk("out_valid", DW'(out_valid), DW'(valid_e));
        chk("out_data", out_data, data_e);
        chk("out_last", DW'(out_last), DW'(last_e));
        chk("ack", DW'(ack), DW'(m_ack));
        chk("timeout_err", DW'(timeout_err), DW'(m_terr));

        abort = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
        if (owner >= 0) begin
            if (fire_e) begin
                stalls = 0;
            end else begin
                stalls++;
                if (stalls == TIMEOUT) abort = 1'b1;
            end
        end
`endif
        m_terr = abort;
        if (owner < 0) begin
            if (req_v != 4'b0000) begin
                owner       = pick(req_v);
                last_winner = owner;
                m_sel       = owner;
                stalls      = 0;
            end
        end else if ((fire_e && last_e) || abort) begin
            if ((req_v & ~grant_e) != 4'b0000) begin
                owner       = pick(req_v);
                last_winner = owner;
                m_sel       = owner;
                stalls      = 0;
            end else begin
                owner = -1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset applied between clock edges; outputs must clear at once.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #2;
        chk({tag, "_grant"}, DW'(grant), '0);
        chk({tag, "_sel"}, DW'(sel), '0);
        chk({tag, "_busy"}, DW'(busy), '0);
        chk({tag, "_valid"}, DW'(out_valid), '0);
        chk({tag, "_ack"}, DW'(ack), '0);
        chk({tag, "_data"}, out_data, '0);
        model_reset();
        req_v = 4'b0000;
        last_v = 4'b0000;
        rdy_v = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] fair_exp[8];
        int         rem[4];
        logic       pres[4];
        int         pulses;
        logic [3:0] to_grant_exp;
        int         to_pulses_exp;

        fair_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        rst_n = 1'b0;
        req = 4'b0000;
        last = 4'b0000;
        data0 = '0;
        data1 = '0;
        data2 = '0;
        data3 = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) dv[i] = '0;
        #1;
        do_reset("reset");
        cycle();

        // Fairness: all four request continuously; each leaves after its second beat.
        req_v = 4'b1111;
        last_v = 4'b1111;
        rdy_v = 1'b1;
        for (int i = 0; i < 4; i++) dv[i] = 32'h1000_0000 + 32'(i);
        cycle();
        chk("fair_arb_cycle_idle", DW'(g_busy), '0);
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("fair_grant", DW'(g_grant), DW'(fair_exp[k]));
            if (k >= 4) req_v[k % 4] = 1'b0;
        end
        cycle();
        chk("fair_done_idle", DW'(g_busy), '0);

        // Single beat.
        req_v = 4'b0001;
        last_v = 4'b0001;
        dv[0] = 32'hDEADBEEF;
        cycle();
        cycle();
        chk("single_grant", DW'(g_grant), DW'(4'b0001));
        chk("single_data", g_data, 32'hDEADBEEF);
        chk("single_ack", DW'(g_ack), DW'(4'b0001));
        req_v = 4'b0000;
        cycle();
        chk("single_then_idle", DW'(g_busy), '0);

        // Burst lock: requester 1 sends three beats while requester 2 waits.
        req_v = 4'b0110;
        last_v = 4'b0100;
        dv[1] = 32'hA1A1_0001;
        dv[2] = 32'hB2B2_0002;
        cycle();
        for (int b = 0; b < 3; b++) begin
            if (b == 2) last_v = 4'b0110;
            cycle();
            chk("burst_grant1", DW'(g_grant), DW'(4'b0010));
        end
        req_v = 4'b0100;
        cycle();
        chk("burst_then_grant2", DW'(g_grant), DW'(4'b0100));
        req_v = 4'b0000;
        cycle();

        // Backpressure: five stalled cycles, then the beat fires.
        req_v = 4'b1000;
        last_v = 4'b1000;
        dv[3] = 32'hCAFEF00D;
        rdy_v = 1'b0;
        cycle();
        for (int s = 0; s < 5; s++) begin
            cycle();
            chk("bp_grant", DW'(g_grant), DW'(4'b1000));
            chk("bp_data", g_data, 32'hCAFEF00D);
            chk("bp_no_ack", DW'(g_ack), '0);
        end
        rdy_v = 1'b1;
        cycle();
        chk("bp_fire_ack", DW'(g_ack), DW'(4'b1000));
        req_v = 4'b0000;
        cycle();

        // Reset in the middle of a stalled burst.
        req_v = 4'b0010;
        last_v = 4'b0000;
        rdy_v = 1'b0;
        cycle();
        cycle();
        chk("midburst_busy", DW'(g_busy), DW'(1'b1));
        do_reset("midburst_reset");

        // Long stall with requesters 0 and 1 pending.
`ifdef WB_ARB_TIMEOUT_EN
        to_pulses_exp = 1;
        to_grant_exp  = 4'b0010;
`else
        to_pulses_exp = 0;
        to_grant_exp  = 4'b0001;
`endif
        req_v = 4'b0011;
        last_v = 4'b0011;
        dv[0] = 32'h0000_00AA;
        dv[1] = 32'h0000_00BB;
        rdy_v = 1'b0;
        pulses = 0;
        cycle();
        for (int s = 0; s < 20; s++) begin
            cycle();
            if (g_terr) pulses++;
            chk("stall_no_ack0", DW'(g_ack[0]), '0);
        end
        chk("stall_err_pulses", DW'(pulses), DW'(to_pulses_exp));
        chk("stall_final_grant", DW'(g_grant), DW'(to_grant_exp));
        do_reset("post_stall_reset");

        // Randomized traffic: bursts of 1..4 beats, gaps between beats, random ready.
        for (int i = 0; i < 4; i++) begin
            rem[i] = 0;
            pres[i] = 1'b0;
        end
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pres[i]) begin
                    if (rem[i] == 0 && $urandom_range(0, 5) == 0) rem[i] = $urandom_range(1, 4);
                    if (rem[i] > 0 && $urandom_range(0, 4) != 0) begin
                        pres[i] = 1'b1;
                        dv[i] = $urandom;
                    end
                end
                req_v[i]  = pres[i];
                last_v[i] = pres[i] && (rem[i] == 1);
            end
            rdy_v = ($urandom_range(0, 3) != 0);
            cycle();
            for (int i = 0; i < 4; i++) begin
                if (m_ack[i]) begin
                    pres[i] = 1'b0;
                    rem[i]--;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
